// File: rtl/alu_iter.sv
// alu_iter: handshaked multi-cycle ALU execution unit.
//
// Logic ops, add/sub and signed compare complete in one cycle; shifts run one bit per cycle
// through a working register to keep the shifter small.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   request handshake; in_op, in_a, in_b sampled only on acceptance
//   out_valid / out_ready response handshake; out_result and out_zero held until consumed
//   busy                  unit is not idle
//
// Configuration macro:
//   ALU_ITER_SRA_EN  enables op 8 as an arithmetic right shift; otherwise op 8 is undefined.
module alu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             busy
);

  localparam int unsigned SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpSlt = 4'd5;
  localparam logic [3:0] OpSll = 4'd6;
  localparam logic [3:0] OpSrl = 4'd7;
`ifdef ALU_ITER_SRA_EN
  localparam logic [3:0] OpSra = 4'd8;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q;
  logic [SW-1:0]    count_q;
  logic             left_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
`ifdef ALU_ITER_SRA_EN
  logic             arith_q;
`endif

  logic             accept;
  logic             is_shift;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] shifted;
  logic             fill;

  assign accept = in_valid && (state_q == StIdle);
  assign shamt  = in_b[SW-1:0];

  // Single-cycle result for non-shift ops; undefined ops produce zero.
  always_comb begin
    alu_res  = '0;
    is_shift = 1'b0;
    case (in_op)
      OpAdd: alu_res = in_a + in_b;
      OpSub: alu_res = in_a - in_b;
      OpAnd: alu_res = in_a & in_b;
      OpOr:  alu_res = in_a | in_b;
      OpXor: alu_res = in_a ^ in_b;
      OpSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OpSll: is_shift = 1'b1;
      OpSrl: is_shift = 1'b1;
`ifdef ALU_ITER_SRA_EN
      OpSra: is_shift = 1'b1;
`endif
      default: alu_res = '0;
    endcase
  end

  // One-bit step of the iterative shifter.
`ifdef ALU_ITER_SRA_EN
  assign fill = arith_q & a_q[WIDTH-1];
`else
  assign fill = 1'b0;
`endif
  assign shifted = left_q ? {a_q[WIDTH-2:0], 1'b0} : {fill, a_q[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (is_shift && (shamt != '0)) ? StShift : StDone;
        end
      end
      StShift: begin
        if (count_q == SW'(1)) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready   = (state_q == StIdle);
    out_valid  = (state_q == StDone);
    busy       = (state_q != StIdle);
    out_result = result_q;
    out_zero   = zero_q;
  end

  // Datapath: operand capture, shift iteration and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      count_q  <= '0;
      left_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_ITER_SRA_EN
      arith_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (is_shift) begin
              a_q     <= in_a;
              count_q <= shamt;
              left_q  <= (in_op == OpSll);
`ifdef ALU_ITER_SRA_EN
              arith_q <= (in_op == OpSra);
`endif
              // A zero shift amount bypasses the iteration entirely.
              if (shamt == '0) begin
                result_q <= in_a;
                zero_q   <= (in_a == '0);
              end
            end else begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
            end
          end
        end
        StShift: begin
          a_q     <= shifted;
          count_q <= count_q - SW'(1);
          if (count_q == SW'(1)) begin
            result_q <= shifted;
            zero_q   <= (shifted == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_op = 4'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int lat;

  alu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, let it be accepted, scramble inputs, and count cycles until out_valid.
  // The acceptance edge counts as cycle 1.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int cyc);
    @(negedge clk);
    check("in_ready_before", W'(in_ready), W'(1));
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 4'd0; in_a = '1; in_b = '1;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Full op with out_ready held high: latency, data, then return to idle.
  task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp_res, input logic exp_zero,
                     input int exp_lat);
    int c;
    do_op(op, a, b, c);
    check({tag, "_lat"}, W'(c), W'(exp_lat));
    check({tag, "_res"}, out_result, exp_res);
    check({tag, "_zero"}, W'(out_zero), W'(exp_zero));
    check({tag, "_rdy_low"}, W'(in_ready), W'(0));
    @(posedge clk); #1;
    check({tag, "_idle_valid"}, W'(out_valid), W'(0));
    check({tag, "_idle_rdy"}, W'(in_ready), W'(1));
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_result", out_result, '0);
    check("rst_zero", W'(out_zero), W'(0));
    check("rst_busy", W'(busy), W'(0));
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle ops.
    run("add", 4'd0, 32'd10, 32'd20, 32'd30, 1'b0, 1);
    run("sub", 4'd1, 32'd30, 32'd30, 32'd0, 1'b1, 1);
    run("and", 4'd2, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 1'b1, 1);
    run("or",  4'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1);
    run("xor", 4'd4, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1);
    run("slt_neg", 4'd5, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1);
    run("slt_gt", 4'd5, 32'd20, 32'd10, 32'd0, 1'b1, 1);

    // Iterative shifts.
    run("sll2", 4'd6, 32'd8, 32'd2, 32'd32, 1'b0, 3);
    run("srl2", 4'd7, 32'd32, 32'd2, 32'd8, 1'b0, 3);
    run("sll0", 4'd6, 32'd5, 32'd0, 32'd5, 1'b0, 1);
    run("sll31", 4'd6, 32'd1, 32'd31, 32'h80000000, 1'b0, 32);
    run("sll_b25", 4'd6, 32'd1, 32'h25, 32'h20, 1'b0, 6);
    run("srl4", 4'd7, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 5);

    // Undefined op after a nonzero result.
    run("op9", 4'd9, 32'h1234, 32'h5678, 32'h0, 1'b1, 1);

    // Op 8 depends on configuration.
`ifdef ALU_ITER_SRA_EN
    run("sra4", 4'd8, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 5);
`else
    run("op8", 4'd8, 32'h80000000, 32'd4, 32'h0, 1'b1, 1);
`endif

    // Backpressure: result held, new request refused.
    out_ready = 1'b0;
    do_op(4'd0, 32'd1, 32'd1, lat);
    check("bp_lat", W'(lat), W'(1));
    check("bp_res", out_result, 32'd2);
    in_op = 4'd0; in_a = 32'd5; in_b = 32'd5; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", W'(out_valid), W'(1));
      check("bp_hold_res", out_result, 32'd2);
      check("bp_hold_rdy", W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_valid", W'(out_valid), W'(0));
    check("bp_rel_busy", W'(busy), W'(0));
    check("bp_rel_res", out_result, 32'd2);

    // Reset mid-shift.
    @(negedge clk);
    in_op = 4'd7; in_a = 32'hFFFFFFFF; in_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("mid_busy_pre", W'(busy), W'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", W'(out_valid), W'(0));
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_res", out_result, '0);
    check("mid_rst_zero", W'(out_zero), W'(0));
    check("mid_rst_rdy", W'(in_ready), W'(1));
    @(negedge clk);
    rst = 1'b0;
    run("post_rst_add", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
